// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
// Holds the handshake state encoding and the baud divisor helper.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rx_state_t;

  localparam int DEFAULT_DIV = 27;

  // Divisor for a 16x oversampling tick at the given system clock and baud rate.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO; dout shows the head entry while not empty.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; only entries between the pointers are ever visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: oversample tick generator, rdy/rdy_clr handshake with the
// receiver, and a byte FIFO with a valid/ready consumer port and sticky overrun flag.
module uart_rx_ctrl #(
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_we,
  output logic                          clken,
  input  logic                          rx_rdy,
  input  logic [7:0]                    rx_data,
  output logic                          rdy_clr,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clr
);

  import uart_pkg::*;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] tick_cnt;
  rx_state_t        state;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign push    = (state == IDLE) && rx_rdy;
  assign pop     = m_valid && m_ready;
  assign m_valid = !empty;

  // Divisors of 0 and 1 both collapse to a tick on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DIV_W'(DEFAULT_DIV);
      tick_cnt <= '0;
      clken    <= 1'b0;
    end else if (cfg_we) begin
      div      <= cfg_div;
      tick_cnt <= '0;
      clken    <= 1'b0;
    end else if (!en) begin
      tick_cnt <= '0;
      clken    <= 1'b0;
    end else if (div <= DIV_W'(1) || tick_cnt == div - 1'b1) begin
      tick_cnt <= '0;
      clken    <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      clken    <= 1'b0;
    end
  end

  // rx_rdy is ignored while in CLEAR so a byte is captured once before the receiver drops rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdy_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            state   <= CLEAR;
            rdy_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= IDLE;
          rdy_clr <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rdy_clr <= 1'b0;
        end
      endcase
    end
  end

  // A dropped byte outranks a clear request arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (m_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

endmodule
